lms_mc_update_engine: RTL
=========================

// Module: lms_mc_update_engine
// PURPOSE
//  Multi-channel, time-multiplexed LMS weight-update engine; successor to the single-channel LMS block.
//  Per channel: holds an N-tap u delay line and N weights; on each (u,e) sample pair applies
//  w[i] += (MU*e)*u[i], ADD_STEP taps per cycle, saturating. Sits between ANC sample front-end and FIR.
// PARAMETERS
//  N         32   taps per channel
//  CH        4    channel count (CH_W = max(1,$clog2(CH)))
//  IN_W      20   u/e sample width, signed, R_IN frac bits
//  OUT_W     20   weight width, signed, R_OUT frac bits
//  MU_W      8    step-size width, unsigned, R_MU frac bits
//  R_IN      18 | R_OUT 18 | R_MU 9   fractional bit counts
//  MU        102  step size (0.199)
//  ADD_STEP  4    taps updated per cycle; N % ADD_STEP == 0 (elaboration $error otherwise)
//  LEAK_SH   10   leakage shift (used only with LMS_LEAKAGE_EN)
// PORTS
//  clock       in   1              rising-edge clock
//  reset_n     in   1              asynchronous, active-low reset
//  valid_in    in   1              u/e pair valid
//  ch_in       in   CH_W           channel of pair
//  data_u_in   in   IN_W           reference sample u (signed)
//  data_e_in   in   IN_W           error sample e (signed)
//  ready       out  1              engine idle, pair will be accepted
//  clear       in   1              sync: zero weights+delay line of ch_in (when ready)
//  data_out    out  N*OUT_W        weights of ch_out, packed, tap 0 in LSBs
//  ch_out      out  CH_W           channel of data_out
//  valid_out   out  1              one-cycle pulse, data_out/ch_out valid
//  overrun     out  1              sticky: pair dropped while busy; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release): all weights/delay lines 0, FSM IDLE, ready=1, valid_out=0,
//   data_out=0, ch_out=0, overrun=0. Reset mid-update aborts; partial update is discarded.
//  FSM: IDLE -> STEP -> UPD (N/ADD_STEP cycles) -> DONE -> IDLE.
//   IDLE: ready=1. valid_in: shift data_u_in into u_line[ch_in][0], old taps move up, tap N-1 lost;
//    latch e, ch -> STEP. clear && !valid_in: zero channel, stay IDLE. clear && valid_in: clear wins, pair dropped (not overrun).
//   STEP: step = sat_IN_W((MU*e) >>> R_MU) (arith shift, floor). ready=0.
//   UPD: tap group k: for i in [k*ADD_STEP, (k+1)*ADD_STEP): w[i] = sat_OUT_W(w[i] + ((step*u[i]) >>> (2*R_IN-R_OUT))).
//    Intermediate full precision (2*IN_W bits + guard); saturation to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   DONE: valid_out=1 for one cycle, data_out = updated weights, ch_out = ch -> IDLE (ready=1 next cycle).
//  Latency valid_in -> valid_out = N/ADD_STEP + 2 cycles (10 for defaults); throughput 1 pair per N/ADD_STEP+3.
//  valid_in while ready=0: pair dropped, overrun set; state unaffected.
//  ch_in >= CH (non-power-of-2 CH): pair dropped, overrun set.
//  data_out holds last value between pulses.
// CONFIGURATION
//  LMS_LEAKAGE_EN defined: UPD uses w[i] = sat(w[i] - (w[i] >>> LEAK_SH) + delta), leaky LMS.
//  Undefined: plain LMS as above; LEAK_SH unused. Latency identical in both builds.
// STRUCTURE
//  Package lms_pkg: fixed-point typedefs (sample_t, weight_t, mu_t), fsm state enum, sat() function,
//   default frac-bit constants.
//  Sub-module lms_tap_update: one combinational+sat tap lane (w, u, step -> w'); instantiated ADD_STEP times.
//  Storage: weights and u lines as CH x N register arrays; the tap-group counter drives the lane mux.
// TESTING  (defaults unless noted; 1.0 = 262144)
//  1 Reset, ch0 u=262144 e=131072 -> valid_out after 10 cycles, ch_out=0, w[0]=26112, w[1..31]=0.
//  2 Then ch0 u=0 e=131072 -> w[1]=26112 (delay shift), w[0]=26112; ch1 weights still all 0.
//  3 ch2 u=524287 e=524287 x3 pairs -> w[0]=208893, 417786, then 524287 (saturated, no wrap).
//  4 valid_in asserted 3 cycles after accepted pair -> dropped, overrun=1, only one valid_out seen.
//  5 clear on ch0 after test 2, then u=0,e=0 pair -> data_out all 0 for ch0; other channels intact.
//  6 reset_n low mid-UPD -> outputs at reset values immediately; next pair behaves as test 1.
//  (LMS_LEAKAGE_EN build: test 1 repeated with zero-error pairs -> w[0] decays 26112->26087.)

Source files
------------

// File: rtl/lms_pkg.sv
// Shared fixed-point types, FSM encoding and saturation helper for the multi-channel LMS engine.
// Default widths and fractional-bit counts live here so the top and tap lanes agree on them.
package lms_pkg;

  localparam int DEF_N        = 32;
  localparam int DEF_CH       = 4;
  localparam int DEF_IN_W     = 20;
  localparam int DEF_OUT_W    = 20;
  localparam int DEF_MU_W     = 8;
  localparam int DEF_R_IN     = 18;
  localparam int DEF_R_OUT    = 18;
  localparam int DEF_R_MU     = 9;
  localparam int DEF_MU       = 102;
  localparam int DEF_ADD_STEP = 4;
  localparam int DEF_LEAK_SH  = 10;

  typedef logic signed [DEF_IN_W-1:0]  sample_t;
  typedef logic signed [DEF_OUT_W-1:0] weight_t;
  typedef logic        [DEF_MU_W-1:0]  mu_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_UPD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      sat = hi;
    else if (x < lo) sat = lo;
    else             sat = x;
  endfunction

endpackage

// File: rtl/lms_tap_update.sv
// One combinational tap lane: w' = sat(w + (step*u) >>> (2*R_IN-R_OUT)).
// With LMS_LEAKAGE_EN defined the lane also subtracts w >>> LEAK_SH (leaky LMS).
module lms_tap_update
  import lms_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int R_IN    = DEF_R_IN,
  parameter int R_OUT   = DEF_R_OUT,
  parameter int LEAK_SH = DEF_LEAK_SH
) (
  input  logic signed [OUT_W-1:0] w,
  input  logic signed [IN_W-1:0]  u,
  input  logic signed [IN_W-1:0]  step,
  output logic signed [OUT_W-1:0] w_next
);

  localparam int SH = 2 * R_IN - R_OUT;
  // Full-precision product plus guard bits so the accumulate cannot wrap before saturation.
  localparam int PW = ((2 * IN_W > OUT_W) ? 2 * IN_W : OUT_W) + 2;

  if (LEAK_SH < 0 || LEAK_SH >= OUT_W) begin : g_bad_leak
    $error("lms_tap_update: LEAK_SH out of range");
  end

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] delta;
  logic signed [PW-1:0] acc;

  always_comb begin
    prod  = PW'(step) * PW'(u);
    delta = prod >>> SH;
`ifdef LMS_LEAKAGE_EN
    acc   = PW'(w) - (PW'(w) >>> LEAK_SH) + delta;
`else
    acc   = PW'(w) + delta;
`endif
    w_next = OUT_W'(sat(64'(acc), OUT_W));
  end

endmodule

// File: rtl/lms_mc_update_engine.sv
// Multi-channel time-multiplexed LMS weight-update engine: per-channel u delay line and weights,
// ADD_STEP taps updated per cycle. Optional leaky update when LMS_LEAKAGE_EN is defined.
module lms_mc_update_engine
  import lms_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int CH       = DEF_CH,
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int MU_W     = DEF_MU_W,
  parameter int R_IN     = DEF_R_IN,
  parameter int R_OUT    = DEF_R_OUT,
  parameter int R_MU     = DEF_R_MU,
  parameter int MU       = DEF_MU,
  parameter int ADD_STEP = DEF_ADD_STEP,
  parameter int LEAK_SH  = DEF_LEAK_SH,
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    valid_in,
  input  logic [CH_W-1:0]         ch_in,
  input  logic signed [IN_W-1:0]  data_u_in,
  input  logic signed [IN_W-1:0]  data_e_in,
  output logic                    ready,
  input  logic                    clear,
  output logic [N*OUT_W-1:0]      data_out,
  output logic [CH_W-1:0]         ch_out,
  output logic                    valid_out,
  output logic                    overrun,
  output state_t                  state_dbg
);

  // Handshake: a pair is taken on a rising edge where valid_in=1 and ready=1; valid_in while
  // ready=0 drops the pair and sets the sticky overrun flag. valid_out is a single-cycle pulse.

  localparam int GROUPS = N / ADD_STEP;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int MPW    = IN_W + MU_W + 1;

  if (N % ADD_STEP != 0) begin : g_bad_step
    $error("lms_mc_update_engine: N must be a multiple of ADD_STEP");
  end

  state_t                  state;
  logic [CH_W-1:0]         ch_reg;
  logic signed [IN_W-1:0]  e_reg;
  logic signed [IN_W-1:0]  step_reg;
  logic [G_W-1:0]          grp;

  logic signed [OUT_W-1:0] w_mem [CH][N];
  logic signed [IN_W-1:0]  u_mem [CH][N];

  logic [IDX_W-1:0]        lane_idx [ADD_STEP];
  logic signed [OUT_W-1:0] lane_w   [ADD_STEP];
  logic signed [IN_W-1:0]  lane_u   [ADD_STEP];
  logic signed [OUT_W-1:0] lane_new [ADD_STEP];

  logic signed [MPW-1:0]   mu_prod;
  logic                    ch_in_ok;

  assign state_dbg = state;
  // Only matters for non-power-of-2 CH: codes past the last channel are rejected.
  assign ch_in_ok  = ({1'b0, ch_in} < (CH_W + 1)'(CH));
  assign mu_prod   = MPW'($signed({1'b0, MU_W'(MU)})) * MPW'(e_reg);

  for (genvar j = 0; j < ADD_STEP; j++) begin : g_lane
    assign lane_idx[j] = IDX_W'(int'(grp) * ADD_STEP + j);
    assign lane_w[j]   = w_mem[ch_reg][lane_idx[j]];
    assign lane_u[j]   = u_mem[ch_reg][lane_idx[j]];

    lms_tap_update #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .R_IN    (R_IN),
      .R_OUT   (R_OUT),
      .LEAK_SH (LEAK_SH)
    ) u_lane (
      .w      (lane_w[j]),
      .u      (lane_u[j]),
      .step   (step_reg),
      .w_next (lane_new[j])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ch_reg    <= '0;
      e_reg     <= '0;
      step_reg  <= '0;
      grp       <= '0;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      data_out  <= '0;
      ch_out    <= '0;
      overrun   <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < N; i++) begin
          w_mem[c][i] <= '0;
          u_mem[c][i] <= '0;
        end
      end
    end else begin
      valid_out <= 1'b0;
      if (valid_in && state != S_IDLE) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (clear) begin
            // Clear takes priority; a simultaneous pair is discarded without flagging overrun.
            if (ch_in_ok) begin
              for (int i = 0; i < N; i++) begin
                w_mem[ch_in][i] <= '0;
                u_mem[ch_in][i] <= '0;
              end
            end
          end else if (valid_in) begin
            if (!ch_in_ok) begin
              overrun <= 1'b1;
            end else begin
              u_mem[ch_in][0] <= data_u_in;
              for (int i = 1; i < N; i++) u_mem[ch_in][i] <= u_mem[ch_in][i-1];
              e_reg  <= data_e_in;
              ch_reg <= ch_in;
              ready  <= 1'b0;
              state  <= S_STEP;
            end
          end
        end

        S_STEP: begin
          step_reg <= IN_W'(sat(64'(mu_prod) >>> R_MU, IN_W));
          grp      <= '0;
          state    <= S_UPD;
        end

        S_UPD: begin
          for (int j = 0; j < ADD_STEP; j++) w_mem[ch_reg][lane_idx[j]] <= lane_new[j];
          if (grp == G_W'(GROUPS - 1)) state <= S_DONE;
          else                         grp   <= grp + G_W'(1);
        end

        S_DONE: begin
          for (int i = 0; i < N; i++) data_out[i*OUT_W +: OUT_W] <= w_mem[ch_reg][i];
          ch_out    <= ch_reg;
          valid_out <= 1'b1;
          ready     <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
